// File: rtl/axis_dsp_result_quantizer_pkg.sv
// Shared constants and types for the DSP result quantizer: P-port width,
// the shift clamp used by the DSP wrapper, and the per-beat clip flags.
package axis_dsp_result_quantizer_pkg;

    localparam int DSP_P_WIDTH = 48;
    localparam int SHIFT_MAX   = 47;

    typedef struct packed {
        logic lo;
        logic hi;
    } clip_t;

    // Shifts beyond the P width would leave only the sign bit, so they saturate.
    function automatic logic [5:0] clamp_shift(input logic [5:0] s);
        return (s > 6'(SHIFT_MAX)) ? 6'(SHIFT_MAX) : s;
    endfunction

endpackage

// File: rtl/axis_dsp_result_quantizer_sat_counter.sv
// Saturating event counter. A clear that coincides with an event restarts
// the count at one so the event lands in the new interval.
module sat_counter
    import axis_dsp_result_quantizer_pkg::*;
#(
    parameter int CNT_WIDTH = 24
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 inc_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d    = '0;
            cnt_d[0] = inc_i;
        end else if (inc_i && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/axis_dsp_result_quantizer.sv
// Rounds, shifts and clamps the signed DSP P stream to an unsigned pixel,
// and reports per-frame negative/overflow clip counts on each tlast.
module axis_dsp_result_quantizer
    import axis_dsp_result_quantizer_pkg::*;
#(
    parameter int IN_WIDTH  = DSP_P_WIDTH,
    parameter int OUT_WIDTH = 16,
    parameter int CNT_WIDTH = 24
) (
    input  logic                 axis_aclk,
    input  logic                 axis_aresetn,
    input  logic [5:0]           frac_shift,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic [CNT_WIDTH-1:0] frame_clip_lo,
    output logic [CNT_WIDTH-1:0] frame_clip_hi,
    output logic                 frame_done
);

    localparam int RW = IN_WIDTH + 1;
    localparam logic signed [RW-1:0] PIX_MAX = (RW'(1) << OUT_WIDTH) - RW'(1);

    // Round half toward +inf, then arithmetic shift; one guard bit absorbs the carry.
    function automatic logic signed [RW-1:0] round_shift(input logic [IN_WIDTH-1:0] x,
                                                         input logic [5:0]          s);
        logic signed [RW-1:0] half;
        logic signed [RW-1:0] sum;
        half = (s == 6'd0) ? '0 : $signed(RW'(1) << (s - 6'd1));
        sum  = $signed({x[IN_WIDTH-1], x}) + half;
        return sum >>> s;
    endfunction

    function automatic clip_t clip_of(input logic signed [RW-1:0] r);
        clip_t c;
        c.lo = r[RW-1];
        c.hi = !r[RW-1] && (r > PIX_MAX);
        return c;
    endfunction

    function automatic logic [OUT_WIDTH-1:0] clamp_pix(input logic signed [RW-1:0] r);
        clip_t c;
        c = clip_of(r);
        if (c.lo) return '0;
        if (c.hi) return '1;
        return r[OUT_WIDTH-1:0];
    endfunction

    logic [5:0]           shift_s;
    logic                 adv1, adv2;
    logic                 vld_p1_q, vld_p1_d;
    logic signed [RW-1:0] res_p1_q;
    logic                 last_p1_q;
    logic                 vld_p2_q, vld_p2_d;
    logic [OUT_WIDTH-1:0] pix_p2_q, pix_p2_d;
    logic                 last_p2_q, last_p2_d;
    clip_t                clip_p1;
    logic                 evt_lo, evt_hi, hs_last;
    logic [CNT_WIDTH-1:0] run_lo, run_hi;
    logic [CNT_WIDTH-1:0] frame_lo_q, frame_hi_q;
    logic                 frame_done_q;

    assign shift_s       = clamp_shift(frac_shift);
    assign adv2          = ~vld_p2_q | m_axis_tready;
    assign adv1          = ~vld_p1_q | adv2;
    assign s_axis_tready = adv1;

    // Stage S1: round and shift
    always_ff @(posedge axis_aclk) begin
        if (adv1 && s_axis_tvalid) begin
            res_p1_q  <= round_shift(s_axis_tdata, shift_s);
            last_p1_q <= s_axis_tlast;
        end
    end

    // Stage S2: clamp; clip events are taken as a beat moves in
    assign clip_p1 = clip_of(res_p1_q);
    assign evt_lo  = adv2 & vld_p1_q & clip_p1.lo;
    assign evt_hi  = adv2 & vld_p1_q & clip_p1.hi;
    assign hs_last = vld_p2_q & m_axis_tready & last_p2_q;

    always_comb begin
        vld_p1_d  = adv1 ? s_axis_tvalid : vld_p1_q;
        vld_p2_d  = vld_p2_q;
        pix_p2_d  = pix_p2_q;
        last_p2_d = last_p2_q;
        if (adv2) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                pix_p2_d  = clamp_pix(res_p1_q);
                last_p2_d = last_p1_q;
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            vld_p1_q     <= 1'b0;
            vld_p2_q     <= 1'b0;
            pix_p2_q     <= '0;
            last_p2_q    <= 1'b0;
            frame_lo_q   <= '0;
            frame_hi_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            vld_p1_q     <= vld_p1_d;
            vld_p2_q     <= vld_p2_d;
            pix_p2_q     <= pix_p2_d;
            last_p2_q    <= last_p2_d;
            frame_done_q <= hs_last;
            if (hs_last) begin
                frame_lo_q <= run_lo;
                frame_hi_q <= run_hi;
            end
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_clip_lo (
        .clk_i  (axis_aclk),
        .rst_ni (axis_aresetn),
        .inc_i  (evt_lo),
        .clr_i  (hs_last),
        .cnt_o  (run_lo)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_clip_hi (
        .clk_i  (axis_aclk),
        .rst_ni (axis_aresetn),
        .inc_i  (evt_hi),
        .clr_i  (hs_last),
        .cnt_o  (run_hi)
    );

    assign m_axis_tvalid = vld_p2_q;
    assign m_axis_tdata  = pix_p2_q;
    assign m_axis_tlast  = last_p2_q;
    assign frame_clip_lo = frame_lo_q;
    assign frame_clip_hi = frame_hi_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_axis_dsp_result_quantizer.sv
// Directed + randomized bench for the result quantizer, checked against a
// per-beat arithmetic model and per-frame clip tallies in output order.
module tb_axis_dsp_result_quantizer;

    localparam int CMAX = 15;  // all-ones of the 4-bit counters used here

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  frac_shift;
    logic [47:0] s_tdata;
    logic        s_tvalid, s_tready, s_tlast;
    logic [15:0] m_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic [3:0]  frame_clip_lo, frame_clip_hi;
    logic        frame_done;

    axis_dsp_result_quantizer #(.IN_WIDTH(48), .OUT_WIDTH(16), .CNT_WIDTH(4)) dut (
        .axis_aclk     (clk),
        .axis_aresetn  (rst_n),
        .frac_shift    (frac_shift),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .frame_clip_lo (frame_clip_lo),
        .frame_clip_hi (frame_clip_hi),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pix;
        logic        last;
        logic        lo;
        logic        hi;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_bad = 0;
    int          run_lo = 0, run_hi = 0, exp_flo = 0, exp_fhi = 0;
    logic        pend_done = 1'b0;
    logic        hold_vld = 1'b0;
    logic [15:0] hold_data;
    logic        hold_last;
    logic        rand_rdy = 1'b0;
    logic        in_acc = 1'b0;

    // Pixel = floor((P + half LSB) / 2^s), then clamped to [0, 65535].
    function automatic exp_t model(input logic [47:0] p, input logic [5:0] fs, input logic last);
        exp_t   e;
        int     s;
        longint x, d, num, q;
        s   = (fs > 6'd47) ? 47 : int'(fs);
        x   = longint'($signed(p));
        d   = longint'(1) << s;
        num = x + ((s == 0) ? longint'(0) : d / 2);
        q   = num / d;
        if (num < 0 && q * d != num) q = q - 1;
        e.last = last;
        e.lo   = (q < 0);
        e.hi   = (q > 65535);
        e.pix  = e.lo ? 16'h0000 : (e.hi ? 16'hFFFF : 16'(q));
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: observe outputs on the falling edge, then drive after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        check("frame_done", frame_done, pend_done);
        if (pend_done) begin
            check("frame_clip_lo", frame_clip_lo, exp_flo);
            check("frame_clip_hi", frame_clip_hi, exp_fhi);
        end
        pend_done = 1'b0;
        if (m_tvalid && !m_tready) begin
            if (hold_vld) begin
                check("stall_tdata", m_tdata, hold_data);
                check("stall_tlast", m_tlast, hold_last);
            end
            hold_vld  = 1'b1;
            hold_data = m_tdata;
            hold_last = m_tlast;
        end else begin
            hold_vld = 1'b0;
        end
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                check("spurious_beat", m_tvalid, 0);
            end else begin
                e = exp_q.pop_front();
                check("tdata", m_tdata, e.pix);
                check("tlast", m_tlast, e.last);
                run_lo = (run_lo + int'(e.lo) > CMAX) ? CMAX : run_lo + int'(e.lo);
                run_hi = (run_hi + int'(e.hi) > CMAX) ? CMAX : run_hi + int'(e.hi);
                if (e.last) begin
                    exp_flo   = run_lo;
                    exp_fhi   = run_hi;
                    run_lo    = 0;
                    run_hi    = 0;
                    pend_done = 1'b1;
                end
            end
        end
        in_acc = s_tvalid && s_tready;
        if (in_acc) exp_q.push_back(model(s_tdata, frac_shift, s_tlast));
        @(posedge clk);
        #1;
        if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input longint p, input logic last);
        int n;
        s_tdata  = 48'(p);
        s_tlast  = last;
        s_tvalid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!in_acc && n < 200);
        if (!in_acc) check("send_timeout", in_acc, 1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < 400) begin
            tick();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        tick();
        tick();
    endtask

    initial begin
        longint base, p;
        rst_n      = 1'b0;
        frac_shift = 6'd4;
        s_tdata    = '0;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        m_tready   = 1'b1;
        #12;
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_clip_lo", frame_clip_lo, 0);
        check("rst_clip_hi", frame_clip_hi, 0);
        check("rst_done", frame_done, 0);
        check("rst_s_tready", s_tready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Rounding
        send(296, 0);
        send(295, 0);
        send(-40, 1);
        drain();
        frac_shift = 6'd0;
        send(1234, 1);
        drain();

        // Clamp and shift limits
        frac_shift = 6'd4;
        send(longint'(1) << 20, 0);
        send(48'hFFFF0, 0);
        send(-1, 1);
        drain();
        frac_shift = 6'd47;
        send((longint'(1) << 47) - 1, 0);
        frac_shift = 6'd47;
        drain();
        frac_shift = 6'd63;
        send((longint'(1) << 47) - 1, 1);
        drain();

        // Fill S1 and S2 against a stalled sink
        frac_shift = 6'd4;
        m_tready   = 1'b0;
        tick();
        check("empty_s_tready", s_tready, 1);
        send(5000, 0);
        send(6000, 1);
        check("full_s_tready", s_tready, 0);
        check("full_tvalid", m_tvalid, 1);
        repeat (5) begin
            tick();
            check("stall_s_tready", s_tready, 0);
        end
        m_tready = 1'b1;
        drain();

        // Ramp under random backpressure
        rand_rdy = 1'b1;
        base = longint'($urandom_range(0, 60000)) * 16 - 2000;
        for (int i = 0; i < 32; i++) send(base + longint'(i) * 37 * 16 + 7, (i == 31));
        drain();
        rand_rdy = 1'b0;
        m_tready = 1'b1;

        // Frame stats: 3 hi + 1 lo, last beat is a hi clip; then a clean frame
        send(100 * 16, 0);
        send(longint'(1) << 20, 0);
        send(-1000, 0);
        send(200 * 16, 0);
        send(longint'(1) << 21, 0);
        send(300 * 16, 0);
        send(400 * 16, 0);
        send(longint'(1) << 20, 1);
        drain();
        for (int i = 0; i < 4; i++) send(longint'(i) * 160 + 16, (i == 3));
        drain();

        // Counter saturation with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 20; i++) send((longint'(1) << 20) + longint'(i), (i == 19));
        drain();
        rand_rdy = 1'b0;
        m_tready = 1'b1;

        // Clip beat entering S2 on the tlast handshake belongs to the next frame
        send(50 * 16, 0);
        send(60 * 16, 1);
        send(longint'(1) << 22, 0);
        send(-77, 0);
        send(70 * 16, 1);
        drain();

        // Random shifts and data
        rand_rdy = 1'b1;
        for (int r = 0; r < 3; r++) begin
            frac_shift = 6'($urandom_range(0, 63));
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(0, 3) == 0)
                    p = longint'({$urandom, $urandom});
                else
                    p = (longint'($urandom_range(0, 140000)) - 4000) <<< ((frac_shift > 6'd40) ? 0 : int'(frac_shift));
                send(p, ($urandom_range(0, 7) == 0) || (i == 29));
            end
            drain();
        end
        rand_rdy   = 1'b0;
        m_tready   = 1'b1;
        frac_shift = 6'd4;

        // Reset mid-frame with partial clip counts and two beats in flight
        send(longint'(1) << 20, 0);
        send(-500, 0);
        tick();
        tick();
        m_tready = 1'b0;
        send(700 * 16, 0);
        send(longint'(1) << 20, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_tvalid", m_tvalid, 0);
        check("midrst_clip_lo", frame_clip_lo, 0);
        check("midrst_clip_hi", frame_clip_hi, 0);
        check("midrst_done", frame_done, 0);
        exp_q.delete();
        run_lo    = 0;
        run_hi    = 0;
        pend_done = 1'b0;
        hold_vld  = 1'b0;
        tick();
        rst_n    = 1'b1;
        m_tready = 1'b1;
        tick();
        tick();
        send(longint'(1) << 20, 0);
        send(900 * 16, 0);
        send(-16, 1);
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
